// File: rtl/uart_tx.sv
// UART transmitter: one start bit, DATA_WIDTH data bits LSB first, STOP_BITS stop bits, no parity.
// Accepts one word per frame over a valid/ready handshake; tx_o is driven from a flop.
module uart_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  tx_o,
    output logic                  busy_o
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BIT_W      = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (BIT_CYCLES < 2) begin : g_bad_bit_cycles
        $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end

    logic [1:0]            state, state_n;
    logic [BAUD_W-1:0]     baud_cnt, baud_cnt_n;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_n;
    logic                  stop_cnt, stop_cnt_n;
    logic [DATA_WIDTH-1:0] shift, shift_n;
    logic                  baud_done;
    logic                  accept;
    logic                  tx_n;

    assign baud_done = (baud_cnt == BAUD_LAST);
    assign ready_o   = (state == IDLE);
    assign busy_o    = (state != IDLE);
    assign accept    = valid_i && ready_o;

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_done ? '0 : baud_cnt + 1'b1;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        shift_n    = shift;
        case (state)
            IDLE: begin
                baud_cnt_n = '0;
                if (accept) begin
                    state_n    = START;
                    shift_n    = data_i;
                    bit_cnt_n  = '0;
                    stop_cnt_n = 1'b0;
                end
            end
            START: begin
                if (baud_done) state_n = DATA;
            end
            DATA: begin
                if (baud_done) begin
                    shift_n   = shift >> 1;
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        state_n    = STOP;
                        stop_cnt_n = 1'b0;
                    end
                end
            end
            STOP: begin
                if (baud_done) begin
                    stop_cnt_n = stop_cnt + 1'b1;
                    if (stop_cnt == STOP_LAST) state_n = IDLE;
                end
            end
            default: begin
                state_n    = IDLE;
                baud_cnt_n = '0;
            end
        endcase
    end

    // Line level is decoded from the next state so tx_o changes on the same edge as the state.
    always_comb begin
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
            tx_o     <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            shift    <= shift_n;
            tx_o     <= tx_n;
        end
    end

endmodule
